// File: rtl/if_stage.sv
// Instruction fetch stage of a five-stage pipeline.
// The stage issues one read per cycle into a single-cycle-latency instruction
// SRAM. It hands the fetched instruction and its PC to decode, and it handles
// delayed-branch redirection from decode.
//
// Handshake: a transfer from IF to decode happens on a rising edge where
// fs_to_ds_valid and ds_allowin are both 1. fs_to_ds_bus stays stable while
// fs_to_ds_valid is 1 and ds_allowin is 0.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // The first sequential fetch after reset lands on 0xbfc00000.
  localparam logic [31:0] RESET_PC = 32'hbfbffffc;

  // Fields of the branch bus coming back from decode.
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_redirect;

  // Pipeline control.
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        issue;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  // Stage state.
  logic        fs_valid_q,    fs_valid_d;
  logic [31:0] fs_pc_q,       fs_pc_d;
  logic        fresh_q,       fresh_d;
  logic        buf_valid_q,   buf_valid_d;
  logic [31:0] inst_buf_q,    inst_buf_d;
  logic        br_pending_q,  br_pending_d;
  logic [31:0] pend_target_q, pend_target_d;

  // Decode the branch bus. When br_stall is set, the branch operands are not
  // resolved yet, so br_taken is ignored.
  always_comb begin
    br_stall    = br_bus[33];
    br_taken    = br_bus[32];
    br_target   = br_bus[31:0];
    br_redirect = br_taken & ~br_stall;
  end

  // Pre-IF request, next-PC selection and the SRAM read port.
  always_comb begin
    to_fs_valid     = ~reset & ~br_stall;
    fs_ready_go     = 1'b1;
    fs_allowin      = ~fs_valid_q | (fs_ready_go & ds_allowin);
    issue           = to_fs_valid & fs_allowin;
    seq_pc          = fs_pc_q + 32'd4;
    // A branch that was latched while IF was stalled takes priority over
    // a new redirect. The instruction in IF is the delay slot, so the
    // redirect always applies to the fetch that follows it.
    if (br_pending_q) begin
      nextpc = pend_target_q;
    end else if (br_redirect) begin
      nextpc = br_target;
    end else begin
      nextpc = seq_pc;
    end
    inst_sram_en    = issue;
    inst_sram_addr  = nextpc;
    inst_sram_wen   = 4'h0;
    inst_sram_wdata = 32'h0;
  end

  // Outputs to decode. The SRAM data is only trustworthy in the cycle
  // right after an issue. After that, the buffered copy is used.
  always_comb begin
    fs_inst        = buf_valid_q ? inst_buf_q : inst_sram_rdata;
    fs_to_ds_valid = fs_valid_q & fs_ready_go & ~reset;
    fs_to_ds_bus   = {fs_inst, fs_pc_q};
  end

  // Next-state logic for the stage registers. Synchronous reset is folded in
  // here, so reset clears the buffer and any pending branch on the same edge.
  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    fresh_d       = issue;
    buf_valid_d   = buf_valid_q;
    inst_buf_d    = inst_buf_q;
    br_pending_d  = br_pending_q;
    pend_target_d = pend_target_q;

    if (fs_allowin) begin
      fs_valid_d = to_fs_valid;
    end
    if (issue) begin
      fs_pc_d = nextpc;
    end

    // Capture the read data on the only cycle it is valid, if decode is not
    // taking it. Drop the copy once decode accepts the instruction.
    if (fresh_q & fs_valid_q & ~ds_allowin) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end else if (fs_valid_q & ds_allowin) begin
      buf_valid_d = 1'b0;
    end

    // An issue always consumes the redirect: it uses either the pending
    // target or the live one. Without an issue, remember the newest target.
    if (issue) begin
      br_pending_d = 1'b0;
    end else if (br_redirect) begin
      br_pending_d  = 1'b1;
      pend_target_d = br_target;
    end

    if (reset) begin
      fs_valid_d    = 1'b0;
      fs_pc_d       = RESET_PC;
      fresh_d       = 1'b0;
      buf_valid_d   = 1'b0;
      br_pending_d  = 1'b0;
      pend_target_d = 32'h0;
    end
  end

  // Stage register update.
  always_ff @(posedge clk) begin
    fs_valid_q    <= fs_valid_d;
    fs_pc_q       <= fs_pc_d;
    fresh_q       <= fresh_d;
    buf_valid_q   <= buf_valid_d;
    inst_buf_q    <= inst_buf_d;
    br_pending_q  <= br_pending_d;
    pend_target_q <= pend_target_d;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage. The instruction memory is a pure function of the
// address. Every instruction handed to decode must equal mem(pc), whatever
// the SRAM port shows in cycles without a read.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfbffffc;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [33:0] br_bus = '0;
  logic [31:0] inst_sram_rdata = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what is in IF, and which redirect is still owed.
  logic        m_valid    = 1'b0;
  logic [31:0] m_pc       = RESET_PC;
  logic        m_pend     = 1'b0;
  logic [31:0] m_pend_tgt = 32'h0;

  // Per-cycle snapshot of DUT outputs and model expectations.
  logic        obs_en, obs_valid, exp_en, exp_valid;
  logic [31:0] obs_addr, exp_addr;
  logic [63:0] obs_bus, exp_bus;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc00004) return 32'h24080001;
    return (a * 32'h9e3779b1) ^ 32'h0badc0de;
  endfunction

  // One clock cycle. Sample at the falling edge and work out what the model
  // expects. At the rising edge the SRAM answers the read, or shows random
  // data when no read was made, and the model advances.
  task automatic tick();
    logic stall, redirect;
    @(negedge clk);
    obs_en    = inst_sram_en;
    obs_addr  = inst_sram_addr;
    obs_valid = fs_to_ds_valid;
    obs_bus   = fs_to_ds_bus;
    stall     = br_bus[33];
    redirect  = br_bus[32] & ~stall;
    exp_en    = ~reset & ~stall & (~m_valid | ds_allowin);
    exp_addr  = m_pend ? m_pend_tgt : redirect ? br_bus[31:0] : m_pc + 32'd4;
    exp_valid = m_valid & ~reset;
    exp_bus   = {mem(m_pc), m_pc};
    @(posedge clk);
    #1;
    inst_sram_rdata = obs_en ? mem(obs_addr) : $urandom;
    if (reset) begin
      m_valid = 1'b0; m_pc = RESET_PC; m_pend = 1'b0; m_pend_tgt = 32'h0;
    end else if (exp_en) begin
      m_valid = 1'b1; m_pc = exp_addr; m_pend = 1'b0;
    end else begin
      if (ds_allowin) m_valid = 1'b0;
      if (redirect) begin m_pend = 1'b1; m_pend_tgt = br_bus[31:0]; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (obs_en !== 1'b0) $display("FAIL reset_en: got %b want 0", obs_en); else n_pass++;
      n_checks++; if (obs_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", obs_valid); else n_pass++;
    end
    n_checks++; if (inst_sram_wen !== 4'h0) $display("FAIL wen_tie: got %h want 0", inst_sram_wen); else n_pass++;
    n_checks++; if (inst_sram_wdata !== 32'h0) $display("FAIL wdata_tie: got %h want 0", inst_sram_wdata); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] want_addr [3];
    want_addr[0] = 32'hbfc00000; want_addr[1] = 32'hbfc00004; want_addr[2] = 32'hbfc00008;
    reset = 1'b0; ds_allowin = 1'b1; br_bus = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (obs_en !== 1'b1 || obs_addr !== want_addr[k])
        $display("FAIL seq_addr%0d: got en=%b addr=%h want en=1 addr=%h", k, obs_en, obs_addr, want_addr[k]); else n_pass++;
      n_checks++; if (obs_valid !== (k != 0))
        $display("FAIL seq_valid%0d: got %b want %b", k, obs_valid, (k != 0)); else n_pass++;
      if (k != 0) begin
        n_checks++; if (obs_bus !== {mem(want_addr[k-1]), want_addr[k-1]})
          $display("FAIL seq_bus%0d: got %h want %h", k, obs_bus, {mem(want_addr[k-1]), want_addr[k-1]}); else n_pass++;
      end
    end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    tick(); tick();
    ds_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (obs_en !== 1'b0) $display("FAIL stall_noissue%0d: got %b want 0", k, obs_en); else n_pass++;
      n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {32'h24080001, 32'hbfc00004})
        $display("FAIL stall_hold%0d: got valid=%b bus=%h want 1 2408000_1bfc00004", k, obs_valid, obs_bus); else n_pass++;
    end
    ds_allowin = 1'b1;
    tick();
    n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {32'h24080001, 32'hbfc00004})
      $display("FAIL stall_release_bus: got valid=%b bus=%h want 1 24080001bfc00004", obs_valid, obs_bus); else n_pass++;
    n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'hbfc00008)
      $display("FAIL stall_release_addr: got en=%b addr=%h want 1 bfc00008", obs_en, obs_addr); else n_pass++;
    tick();
    n_checks++; if (obs_bus[31:0] !== 32'hbfc00008)
      $display("FAIL stall_once: got pc=%h want bfc00008", obs_bus[31:0]); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    br_bus = {1'b0, 1'b1, 32'hbfc00100};
    tick();
    n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'hbfc00100)
      $display("FAIL br_addr: got en=%b addr=%h want 1 bfc00100", obs_en, obs_addr); else n_pass++;
    n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {mem(32'hbfc00008), 32'hbfc00008})
      $display("FAIL br_delay_slot: got valid=%b bus=%h", obs_valid, obs_bus); else n_pass++;
    br_bus = '0;
    tick();
    n_checks++; if (obs_bus[31:0] !== 32'hbfc00100 || obs_addr !== 32'hbfc00104)
      $display("FAIL br_follow: got pc=%h addr=%h want bfc00100 bfc00104", obs_bus[31:0], obs_addr); else n_pass++;
  endtask

  task automatic test_branch_pending();
    do_reset();
    tick(); tick();
    ds_allowin = 1'b0; br_bus = {1'b0, 1'b1, 32'hbfc00200};
    tick();
    n_checks++; if (obs_en !== 1'b0 || obs_bus[31:0] !== 32'hbfc00004)
      $display("FAIL pend_hold: got en=%b pc=%h want 0 bfc00004", obs_en, obs_bus[31:0]); else n_pass++;
    ds_allowin = 1'b1; br_bus = '0;
    tick();
    n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'hbfc00200)
      $display("FAIL pend_issue: got en=%b addr=%h want 1 bfc00200", obs_en, obs_addr); else n_pass++;
    n_checks++; if (obs_bus !== {32'h24080001, 32'hbfc00004})
      $display("FAIL pend_slot: got %h want 24080001bfc00004", obs_bus); else n_pass++;
    tick();
    n_checks++; if (obs_bus[31:0] !== 32'hbfc00200 || obs_addr !== 32'hbfc00204)
      $display("FAIL pend_clear: got pc=%h addr=%h want bfc00200 bfc00204", obs_bus[31:0], obs_addr); else n_pass++;
  endtask

  task automatic test_br_stall();
    do_reset();
    tick(); tick();
    br_bus = {1'b1, 1'b1, 32'hbfc00300};
    tick();
    n_checks++; if (obs_en !== 1'b0 || obs_valid !== 1'b1 || obs_bus[31:0] !== 32'hbfc00004)
      $display("FAIL stall1: got en=%b valid=%b pc=%h want 0 1 bfc00004", obs_en, obs_valid, obs_bus[31:0]); else n_pass++;
    tick();
    n_checks++; if (obs_en !== 1'b0 || obs_valid !== 1'b0)
      $display("FAIL stall2: got en=%b valid=%b want 0 0", obs_en, obs_valid); else n_pass++;
    br_bus = {1'b0, 1'b1, 32'hbfc00400};
    tick();
    n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'hbfc00400)
      $display("FAIL stall_release: got en=%b addr=%h want 1 bfc00400", obs_en, obs_addr); else n_pass++;
    br_bus = '0;
    tick();
    n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {mem(32'hbfc00400), 32'hbfc00400})
      $display("FAIL stall_target: got valid=%b bus=%h", obs_valid, obs_bus); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    tick();
    br_bus = {1'b0, 1'b1, 32'hfffffffc};
    tick();
    br_bus = '0;
    tick();
    n_checks++; if (obs_bus[31:0] !== 32'hfffffffc || obs_addr !== 32'h0 || obs_en !== 1'b1)
      $display("FAIL wrap: got pc=%h addr=%h en=%b want fffffffc 0 1", obs_bus[31:0], obs_addr, obs_en); else n_pass++;
    ds_allowin = 1'b0; br_bus = {1'b0, 1'b1, 32'h12345678};
    tick();
    n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {mem(32'h0), 32'h0})
      $display("FAIL wrap_slot: got valid=%b bus=%h", obs_valid, obs_bus); else n_pass++;
    br_bus = '0; reset = 1'b1;
    tick();
    n_checks++; if (obs_valid !== 1'b0 || obs_en !== 1'b0)
      $display("FAIL midreset: got valid=%b en=%b want 0 0", obs_valid, obs_en); else n_pass++;
    reset = 1'b0; ds_allowin = 1'b1;
    tick();
    n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'hbfc00000)
      $display("FAIL restart_addr: got en=%b addr=%h want 1 bfc00000", obs_en, obs_addr); else n_pass++;
    tick();
    n_checks++; if (obs_valid !== 1'b1 || obs_bus !== {mem(32'hbfc00000), 32'hbfc00000})
      $display("FAIL restart_bus: got valid=%b bus=%h", obs_valid, obs_bus); else n_pass++;
  endtask

  task automatic test_random();
    logic stall, taken;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      ds_allowin = ($urandom_range(0, 9) < 7);
      stall      = ($urandom_range(0, 9) < 2);
      taken      = ($urandom_range(0, 9) < 3);
      tgt        = $urandom & 32'hfffffffc;
      br_bus     = {stall, taken, tgt};
      tick();
      n_checks++; if (obs_en !== exp_en)
        $display("FAIL rnd_en @%0d: got %b want %b", i, obs_en, exp_en); else n_pass++;
      if (exp_en) begin
        n_checks++; if (obs_addr !== exp_addr)
          $display("FAIL rnd_addr @%0d: got %h want %h", i, obs_addr, exp_addr); else n_pass++;
      end
      n_checks++; if (obs_valid !== exp_valid)
        $display("FAIL rnd_valid @%0d: got %b want %b", i, obs_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (obs_bus !== exp_bus)
          $display("FAIL rnd_bus @%0d: got %h want %h", i, obs_bus, exp_bus); else n_pass++;
      end
    end
    reset = 1'b0; br_bus = '0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_buffer();
    test_branch();
    test_branch_pending();
    test_br_stall();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ds_allowin, input, 1 bit: decode stage can accept an instruction this cycle.
REQ-004 SHALL have port br_bus, input, 34 bits: [33] br_stall, [32] br_taken, [31:0] br_target.
REQ-005 SHALL have port fs_to_ds_valid, output, 1 bit: fs_to_ds_bus holds a valid instruction.
REQ-006 SHALL have port fs_to_ds_bus, output, 64 bits: [63:32] fs_inst, [31:0] fs_pc.
REQ-007 SHALL have port inst_sram_en, output, 1 bit: instruction SRAM read enable.
REQ-008 SHALL have port inst_sram_wen, output, 4 bits: SRAM byte write enables, tied to 4'h0.
REQ-009 SHALL have port inst_sram_addr, output, 32 bits: SRAM byte address.
REQ-010 SHALL have port inst_sram_wdata, output, 32 bits: SRAM write data, tied to 32'h0.
REQ-011 SHALL have port inst_sram_rdata, input, 32 bits: SRAM read data, valid exactly one cycle after an enabled read.

Function
REQ-012 SHALL implement a pre-IF request: to_fs_valid = ~reset & ~br_stall.
REQ-013 SHALL compute seq_pc = fs_pc + 32'd4, 32-bit modulo, wrapping 0xfffffffc -> 0x00000000.
REQ-014 SHALL compute nextpc: br_pending ? pend_target : (br_taken & ~br_stall) ? br_target : seq_pc.
REQ-015 SHALL drive inst_sram_en = to_fs_valid & fs_allowin and inst_sram_addr = nextpc.
REQ-016 SHALL define fs_ready_go = 1 and fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
REQ-017 SHALL drive fs_to_ds_valid = fs_valid & fs_ready_go.
REQ-018 SHALL update the IF stage on each edge: if fs_allowin, fs_valid <= to_fs_valid; if to_fs_valid & fs_allowin, fs_pc <= nextpc. Otherwise fs_valid and fs_pc hold.
REQ-019 SHALL mark the first cycle after an issue with a 1-bit register, fresh. fresh is set on issue and cleared otherwise.
REQ-020 SHALL capture inst_sram_rdata into inst_buf and set buf_valid when fresh & fs_valid & ~ds_allowin.
REQ-021 SHALL clear buf_valid when fs_valid & ds_allowin, so the buffered instruction is consumed exactly once.
REQ-022 SHALL output fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-023 SHALL never present stale SRAM data while a stalled instruction remains in IF, independent of SRAM output hold behaviour.
REQ-024 SHALL set br_pending and latch pend_target <= br_target when br_taken & ~br_stall and no issue occurs in that cycle.
REQ-025 SHALL clear br_pending on the first issue, which uses pend_target.
REQ-026 SHALL reload pend_target with the latest br_target while br_taken & ~br_stall is held over several cycles without an issue.
REQ-027 SHALL ignore br_taken whenever br_stall = 1 in that cycle, since the branch operands are unresolved.
REQ-028 SHALL issue no request while br_stall = 1; fs_valid SHALL drop after handoff if ds_allowin = 1, else the current instruction holds.
REQ-029 SHALL make the branch target the fetch after the instruction currently in IF (the delay slot); the delay slot is never squashed.
REQ-030 SHALL, when ds_allowin and br_taken rise in the same cycle, issue the target immediately and leave br_pending = 0.

Reset
REQ-031 SHALL, while reset = 1, set fs_valid = 0, buf_valid = 0, fresh = 0, br_pending = 0, fs_pc = 32'hbfbffffc, and pend_target = 0.
REQ-032 SHALL, while reset = 1, drive fs_to_ds_valid = 0 and inst_sram_en = 0.
REQ-033 SHALL, in the first cycle after reset deasserts, issue at address 32'hbfc00000.
REQ-034 SHALL, on reset asserted mid-operation, discard any buffered instruction and any pending branch in the same edge.

Verification
REQ-035 SHALL cover reset release with ds_allowin = 1: SRAM addresses 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles, with fs_pc following one cycle behind.
REQ-036 SHALL cover ds_allowin = 0 for 3 cycles with fs_pc = 0xbfc00004 and rdata = 0x24080001 then changing: fs_inst stays 0x24080001, no new issue, and one handoff occurs on release.
REQ-037 SHALL cover br_taken = 1, br_target = 0xbfc00100 with fs_pc = 0xbfc00008: next SRAM address is 0xbfc00100, and 0xbfc00008 is still delivered to decode.
REQ-038 SHALL cover br_taken = 1 with ds_allowin = 0 and fs_valid = 1, target 0xbfc00200, then ds_allowin = 1 with br_taken = 0: br_pending is set and the next issue is to 0xbfc00200.
REQ-039 SHALL cover br_stall = 1 with br_taken = 1 for 2 cycles, then br_stall = 0: inst_sram_en = 0 during the stall, then an issue to the br_target presented after release.
REQ-040 SHALL cover fs_pc = 0xfffffffc with no branch: next address is 0x00000000; reset asserted with buf_valid = 1 clears buf_valid and restarts at 0xbfc00000.
